// File: rtl/snake_head_stepper.sv
// snake_head_stepper: divides the system clock into game ticks and advances
// the snake head one grid cell per tick, rejecting 180-degree reversals and
// flagging wall collisions with a sticky game-over state.
// Optional feature macro: SNAKE_WRAP_EN (grid edges wrap around, no collisions).
// Direction encodings come from `UP_DIR/`DOWN_DIR/`LEFT_DIR/`RIGHT_DIR; if the
// shared define header has not been read, local defaults are supplied here.

`ifndef UP_DIR
`define UP_DIR    2'b00
`endif
`ifndef DOWN_DIR
`define DOWN_DIR  2'b01
`endif
`ifndef LEFT_DIR
`define LEFT_DIR  2'b10
`endif
`ifndef RIGHT_DIR
`define RIGHT_DIR 2'b11
`endif

module snake_head_stepper #(
   parameter int GRID_W      = 32,
   parameter int GRID_H      = 24,
   parameter int TICK_CYCLES = 2_500_000,
   parameter int START_X     = GRID_W / 2,
   parameter int START_Y     = GRID_H / 2,
   localparam int X_W        = $clog2(GRID_W),
   localparam int Y_W        = $clog2(GRID_H)
) (
   input  logic           i_clock,
   input  logic           i_reset,
   input  logic           i_game_start,
   input  logic [1:0]     i_direction,
   input  logic           i_pause,
   output logic [X_W-1:0] o_head_x,
   output logic [Y_W-1:0] o_head_y,
   output logic           o_step,
   output logic           o_game_over,
   output logic [1:0]     o_state
);

   localparam int CNT_W = $clog2(TICK_CYCLES);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [X_W-1:0]   X_START  = X_W'(START_X);
   localparam logic [Y_W-1:0]   Y_START  = Y_W'(START_Y);

`ifdef SNAKE_WRAP_EN
   localparam logic [X_W-1:0]   X_MAX    = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(GRID_H - 1);
`else
   localparam logic [X_W:0]     X_LIMIT  = (X_W + 1)'(GRID_W);
   localparam logic [Y_W:0]     Y_LIMIT  = (Y_W + 1)'(GRID_H);
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_OVER = 2'b10
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] tick_count, count_next;
   logic [1:0]       last_dir, dir_next, eff_dir;
   logic [X_W-1:0]   head_x, x_next, cand_x;
   logic [Y_W-1:0]   head_y, y_next, cand_y;
   logic             step, step_next;
   logic             game_over, over_next;
   logic             wall_hit;

`ifndef SNAKE_WRAP_EN
   logic [X_W:0]     wide_x;
   logic [Y_W:0]     wide_y;
`endif

   function automatic logic [1:0] opposite_dir(input logic [1:0] d);
      case (d)
         `UP_DIR:   opposite_dir = `DOWN_DIR;
         `DOWN_DIR: opposite_dir = `UP_DIR;
         `LEFT_DIR: opposite_dir = `RIGHT_DIR;
         default:   opposite_dir = `LEFT_DIR;
      endcase
   endfunction

   // Resolve the move direction (reversals fall back to the last move) and the candidate next cell.
   always_comb begin
      eff_dir  = i_direction;
      cand_x   = head_x;
      cand_y   = head_y;
      wall_hit = 1'b0;
      if (i_direction == opposite_dir(last_dir)) begin
         eff_dir = last_dir;
      end
`ifdef SNAKE_WRAP_EN
      case (eff_dir)
         `UP_DIR:   cand_y = (head_y == '0)    ? Y_MAX : head_y - 1'b1;
         `DOWN_DIR: cand_y = (head_y == Y_MAX) ? '0    : head_y + 1'b1;
         `LEFT_DIR: cand_x = (head_x == '0)    ? X_MAX : head_x - 1'b1;
         default:   cand_x = (head_x == X_MAX) ? '0    : head_x + 1'b1;
      endcase
`else
      wide_x = {1'b0, head_x};
      wide_y = {1'b0, head_y};
      case (eff_dir)
         `UP_DIR:   wide_y = {1'b0, head_y} - 1'b1;
         `DOWN_DIR: wide_y = {1'b0, head_y} + 1'b1;
         `LEFT_DIR: wide_x = {1'b0, head_x} - 1'b1;
         default:   wide_x = {1'b0, head_x} + 1'b1;
      endcase
      wall_hit = (wide_x >= X_LIMIT) || (wide_y >= Y_LIMIT);
      cand_x   = wide_x[X_W-1:0];
      cand_y   = wide_y[Y_W-1:0];
`endif
   end

   // Next-state logic: tick counting in RUN, head update or collision on each tick.
   always_comb begin
      state_next = state;
      count_next = tick_count;
      dir_next   = last_dir;
      x_next     = head_x;
      y_next     = head_y;
      step_next  = 1'b0;
      over_next  = game_over;
      case (state)
         ST_IDLE: begin
            count_next = '0;
            if (i_game_start) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!i_pause) begin
               if (tick_count == CNT_LAST) begin
                  count_next = '0;
                  dir_next   = eff_dir;
                  if (wall_hit) begin
                     over_next  = 1'b1;
                     state_next = ST_OVER;
                  end else begin
                     x_next    = cand_x;
                     y_next    = cand_y;
                     step_next = 1'b1;
                  end
               end else begin
                  count_next = tick_count + 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // State and output registers with asynchronous reset to the start position.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         tick_count <= '0;
         last_dir   <= `LEFT_DIR;
         head_x     <= X_START;
         head_y     <= Y_START;
         step       <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         state      <= state_next;
         tick_count <= count_next;
         last_dir   <= dir_next;
         head_x     <= x_next;
         head_y     <= y_next;
         step       <= step_next;
         game_over  <= over_next;
      end
   end

   assign o_head_x    = head_x;
   assign o_head_y    = head_y;
   assign o_step      = step;
   assign o_game_over = game_over;
   assign o_state     = state;

endmodule

// File: doc/snake_head_stepper.md
# snake_head_stepper

Game-tick engine directly downstream of the key-to-direction stage: consumes its registered direction and game-start outputs, divides the system clock into game ticks, and advances the snake head one grid cell per tick. Rejects 180° reversals that occur between ticks and detects wall collisions, driving a sticky game-over state. Head coordinates and the per-tick step pulse feed the body/renderer stages.

## Interface
- GRID_W, 32, grid width in cells (≥2); X_W = $clog2(GRID_W)
- GRID_H, 24, grid height in cells (≥2); Y_W = $clog2(GRID_H)
- TICK_CYCLES, 2_500_000, clock cycles per game tick (≥2)
- START_X, GRID_W/2, head x after reset
- START_Y, GRID_H/2, head y after reset

- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_game_start  in  1  level; high once play has begun
- i_direction  in  2  requested direction, `UP_DIR/`DOWN_DIR/`LEFT_DIR/`RIGHT_DIR from define.vh
- i_pause  in  1  level; freezes tick counter while high
- o_head_x  out  X_W  current head column
- o_head_y  out  Y_W  current head row (0 = top)
- o_step  out  1  one-cycle pulse, head moved this tick
- o_game_over  out  1  sticky collision flag
- o_state  out  2  00 IDLE, 01 RUN, 10 OVER

## Operation
- Reset values: o_head_x=START_X, o_head_y=START_Y, o_step=0, o_game_over=0, o_state=IDLE, tick counter=0, last-move direction=`LEFT_DIR.
- IDLE: counter held at 0; on edge with i_game_start=1 -> RUN.
- RUN: counter increments each edge when i_pause=0; holds when i_pause=1. At edge with counter==TICK_CYCLES-1 (and i_pause=0): counter->0, tick fires.
- On tick: effective dir = i_direction sampled at that edge, unless it is the opposite of last-move direction, in which case last-move direction is reused. Last-move direction <= effective dir.
- Moves: UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1. Arithmetic in X_W+1 / Y_W+1 bits to detect underflow/overflow.
- Legal next cell: head updated, o_step=1 for one cycle.
- Out-of-grid next cell: head unchanged, o_step stays 0, o_game_over<=1, state -> OVER.
- OVER: absorbing; counter frozen, outputs held; exit only via i_reset. i_game_start ignored.
- i_game_start falling in RUN is ignored (no return to IDLE).
- i_pause has no effect in IDLE or OVER.

## Timing
- All outputs registered; no combinational input-to-output paths.
- Edge E0 samples i_game_start=1 -> o_state=RUN after E0. First tick at edge E0+TICK_CYCLES (unpaused); o_step high for the cycle after that edge; thereafter one tick every TICK_CYCLES unpaused cycles.
- Head, o_step, o_game_over, o_state all change on the same tick edge.
- Paused cycles extend the tick period one-for-one; counter value preserved across pause.
- Direction changes between ticks are invisible except the value present at the tick edge.
- i_reset asserts outputs to reset values immediately, independent of i_clock, including mid-tick and in OVER.

## Configuration
- SNAKE_WRAP_EN defined: grid edges wrap (x-1 at 0 -> GRID_W-1, x+1 at GRID_W-1 -> 0; same for y with GRID_H); no wall collision, OVER unreachable, o_game_over constant 0.
- Undefined: wall collision behaviour as in Operation.

## Test plan
(GRID_W=8, GRID_H=6, TICK_CYCLES=4, START 4,3.)
- Reset, i_game_start=1, i_direction=`LEFT_DIR held -> o_step every 4 cycles, x 3,2,1,0; next tick o_game_over=1, x stays 0, o_state=10. With SNAKE_WRAP_EN: x goes 7, no game over.
- Moving LEFT, i_direction=`RIGHT_DIR at tick edge -> reversal rejected, x decrements; then `UP_DIR -> y 2, then `RIGHT_DIR accepted -> x increments.
- Running, i_pause=1 for 10 cycles at counter=2 -> no o_step during pause; first o_step 2 cycles after i_pause falls.
- `UP_DIR from (4,3) -> y 2,1,0, then game over; `DOWN_DIR from reset -> y 4,5, then game over.
- i_reset pulsed mid-tick in RUN at (2,3) -> without a clock edge outputs show (4,3), IDLE, o_step=0; with i_game_start held, first step 4 cycles after RUN re-entry.
- i_game_start=0 for 100 cycles with directions toggling -> o_state IDLE, no o_step, head at (4,3).
